digit_scan_driver: RTL and testbench

Time-multiplexed scan driver for the multi-digit 7-segment display. Sits directly upstream of the per-segment decoder blocks. Latches a packed multi-digit hex value through a ready/valid handshake and presents one 4-bit nibble at a time on `digit_out`; the segment blocks consume that nibble as their `D[3:0]` input. Drives the active-low digit enables in step, with guard blanking between digits and optional leading-zero suppression.

---
 rtl/display_pkg.sv | 14 +
 rtl/lead_zero_mask.sv | 24 ++
 rtl/digit_scan_driver.sv | 139 +++++++++++++
 tb/tb_digit_scan_driver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and state encoding for the digit scan driver
package display_pkg;

    localparam int DIGIT_W          = 4;
    localparam int PRESCALE_DEFAULT = 50000;
    localparam int GUARD_DEFAULT    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ON    = 2'd1,
        ST_GUARD = 2'd2
    } scan_state_t;

endpackage

// File: rtl/lead_zero_mask.sv
// rtl/lead_zero_mask.sv - per-digit mask of nibbles that are leading zeros
module lead_zero_mask
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 4
)
(
    input  logic [DIGIT_W*NUM_DIGITS-1:0] disp_reg,
    output logic [NUM_DIGITS-1:0]         mask
);

    logic zero_above;

    // Walk from the most significant digit down; digit 0 is never a leading zero.
    always_comb begin
        mask       = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (disp_reg[DIGIT_W*i +: DIGIT_W] == '0);
            mask[i]    = zero_above && (i != 0);
        end
    end

endmodule

// File: rtl/digit_scan_driver.sv
// rtl/digit_scan_driver.sv - time-multiplexed 7-segment digit scan with pending buffer
module digit_scan_driver
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = PRESCALE_DEFAULT,
    parameter int GUARD_CYCLES = GUARD_DEFAULT
)
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value_in,
    input  logic                          load,
    output logic                          load_ready,
    input  logic                          blank_lz,
    output logic [DIGIT_W-1:0]            digit_out,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic                          blank,
    output logic                          frame_done
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    // The counter also holds the guard reload, so size it for the larger of the two.
    localparam int CNT_MAX = (PRESCALE > GUARD_CYCLES) ? PRESCALE : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      ON_LOAD    = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]      GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] ALL_OFF    = '1;

    scan_state_t                   state;
    logic [DIGIT_W*NUM_DIGITS-1:0] disp_reg;
    logic [DIGIT_W*NUM_DIGITS-1:0] pend_reg;
    logic                          pend_valid;
    logic [IDX_W-1:0]              idx;
    logic [IDX_W-1:0]              idx_inc;
    logic [CNT_W-1:0]              cnt;
    logic [NUM_DIGITS-1:0]         lz_mask;

    function automatic logic [NUM_DIGITS-1:0] sel_for(input logic [IDX_W-1:0] i);
        return ~(NUM_DIGITS'(1) << i);
    endfunction

    lead_zero_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lead_zero_mask (
        .disp_reg (disp_reg),
        .mask     (lz_mask)
    );

    assign load_ready = ~pend_valid;
    assign idx_inc    = idx + IDX_W'(1);

    // Every entry into ON lands on digit 0 after a display swap, and digit 0 is
    // never blanked, so blank can be registered from the current disp_reg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            disp_reg   <= '0;
            pend_reg   <= '0;
            pend_valid <= 1'b0;
            idx        <= '0;
            cnt        <= '0;
            digit_out  <= '0;
            digit_sel  <= ALL_OFF;
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (load && !pend_valid) begin
                pend_reg   <= value_in;
                pend_valid <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (pend_valid) begin
                        disp_reg   <= pend_reg;
                        pend_valid <= 1'b0;
                        idx        <= '0;
                        cnt        <= ON_LOAD;
                        state      <= ST_ON;
                        digit_sel  <= sel_for('0);
                        digit_out  <= pend_reg[DIGIT_W-1:0];
                        blank      <= 1'b0;
                    end
                end

                ST_ON: begin
                    if (cnt == '0) begin
                        cnt       <= GUARD_LOAD;
                        state     <= ST_GUARD;
                        digit_sel <= ALL_OFF;
                        blank     <= 1'b1;
                    end else begin
                        cnt   <= cnt - CNT_W'(1);
                        blank <= blank_lz & lz_mask[idx];
                    end
                end

                ST_GUARD: begin
                    if (cnt == '0) begin
                        cnt   <= ON_LOAD;
                        state <= ST_ON;
                        if (idx == LAST_IDX) begin
                            idx        <= '0;
                            frame_done <= 1'b1;
                            digit_sel  <= sel_for('0);
                            blank      <= 1'b0;
                            if (pend_valid) begin
                                disp_reg   <= pend_reg;
                                pend_valid <= 1'b0;
                                digit_out  <= pend_reg[DIGIT_W-1:0];
                            end else begin
                                digit_out  <= disp_reg[DIGIT_W-1:0];
                            end
                        end else begin
                            idx       <= idx_inc;
                            digit_sel <= sel_for(idx_inc);
                            digit_out <= disp_reg[DIGIT_W*idx_inc +: DIGIT_W];
                            blank     <= blank_lz & lz_mask[idx_inc];
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    digit_sel <= ALL_OFF;
                    blank     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_scan_driver.sv
// tb/tb_digit_scan_driver.sv - scoreboard bench for digit_scan_driver
module tb_digit_scan_driver;

    localparam int ND = 4;
    localparam int PS = 4;
    localparam int GC = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   value_in;
    logic          load;
    logic          load_ready;
    logic          blank_lz;
    logic [3:0]    digit_out;
    logic [3:0]    digit_sel;
    logic          blank;
    logic          frame_done;

    typedef struct {
        logic [3:0] sel;
        logic [3:0] nib;
        logic       blank;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    digit_scan_driver #(
        .NUM_DIGITS   (ND),
        .PRESCALE     (PS),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .load       (load),
        .load_ready (load_ready),
        .blank_lz   (blank_lz),
        .digit_out  (digit_out),
        .digit_sel  (digit_sel),
        .blank      (blank),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] v, input logic [3:0] bmask,
                              input logic first, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.sel   = ~(4'b0001 << i);
            e.nib   = v[4*i +: 4];
            e.blank = bmask[i];
            e.fd    = (i == 0) && !first;
            sb.push_back(e);
        end
    endtask

    task automatic wait_fd(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!frame_done && cycles < 100);
        if (!frame_done) begin
            total++;
            bad++;
            $display("FAIL wait_frame_done: got timeout after %0d cycles expected pulse", cycles);
        end
    endtask

    task automatic load_once(input logic [15:0] v);
        value_in = v;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Monitor: every digit lighting up is checked against the next scoreboard entry.
    initial begin
        logic [3:0] prev_sel;
        int         run;
        bit         seen;
        exp_t       e;
        prev_sel = 4'hF;
        run      = 0;
        seen     = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_sel = 4'hF;
                run      = 0;
                seen     = 0;
            end else begin
                if (digit_sel != 4'hF && prev_sel == 4'hF) begin
                    if (seen) chk("guard_len", run, GC);
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected: got digit_sel %b with empty scoreboard expected none", digit_sel);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_sel", digit_sel, e.sel);
                        chk("sb_digit", digit_out, e.nib);
                        chk("sb_blank", blank, e.blank);
                        chk("sb_frame_done", frame_done, e.fd);
                    end
                    seen = 1;
                    run  = 1;
                end else if (digit_sel == 4'hF && prev_sel != 4'hF) begin
                    chk("on_len", run, PS);
                    run = 1;
                end else begin
                    run++;
                end
                prev_sel = digit_sel;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        value_in = '0;
        load     = 1'b0;
        blank_lz = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_digit_out", digit_out, 4'h0);
        chk("rst_digit_sel", digit_sel, 4'hF);
        chk("rst_blank", blank, 1'b1);
        chk("rst_load_ready", load_ready, 1'b1);
        chk("rst_frame_done", frame_done, 1'b0);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_sel", digit_sel, 4'hF);
        chk("idle_blank", blank, 1'b1);

        // Basic scan of 1A3F across three frames
        push_frame(16'h1A3F, 4'b0000, 1'b1, 4);
        push_frame(16'h1A3F, 4'b0000, 1'b0, 4);
        push_frame(16'h1A3F, 4'b0000, 1'b0, 4);
        load_once(16'h1A3F);
        chk("accept_ready_low", load_ready, 1'b0);
        chk("accept_sel_still_off", digit_sel, 4'hF);
        @(negedge clk);
        chk("first_latency_sel", digit_sel, 4'b1110);
        chk("swap_ready_high", load_ready, 1'b1);
        wait_fd(n);
        chk("frame_period_1", n, 24);
        wait_fd(n);
        chk("frame_period_2", n, 24);

        // Leading-zero blanking
        blank_lz = 1'b1;
        push_frame(16'h0050, 4'b1100, 1'b0, 4);
        load_once(16'h0050);
        wait_fd(n);
        push_frame(16'h0000, 4'b1110, 1'b0, 4);
        load_once(16'h0000);
        wait_fd(n);

        // Backpressure: second back-to-back load is dropped
        push_frame(16'h1234, 4'b0000, 1'b0, 4);
        push_frame(16'h1234, 4'b0000, 1'b0, 4);
        value_in = 16'h1234;
        load     = 1'b1;
        @(negedge clk);
        chk("bp_ready_low", load_ready, 1'b0);
        value_in = 16'h5678;
        @(negedge clk);
        load     = 1'b0;
        wait_fd(n);

        // Load landing on the frame-boundary cycle shows one frame later
        repeat (23) @(negedge clk);
        push_frame(16'hBEEF, 4'b0000, 1'b0, 3);
        load_once(16'hBEEF);
        chk("boundary_frame_done", frame_done, 1'b1);
        chk("boundary_accept", load_ready, 1'b0);
        wait_fd(n);
        chk("boundary_ready_rise", load_ready, 1'b1);

        // Reset mid-frame with a pending value
        load_once(16'hCAFE);
        chk("pend_cafe_ready", load_ready, 1'b0);
        repeat (12) @(negedge clk);
        chk("mid_digit2_sel", digit_sel, 4'b1011);
        #2 rst_n = 1'b0;
        #1;
        chk("async_digit_out", digit_out, 4'h0);
        chk("async_digit_sel", digit_sel, 4'hF);
        chk("async_blank", blank, 1'b1);
        chk("async_load_ready", load_ready, 1'b1);
        chk("async_frame_done", frame_done, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_reset_idle_sel", digit_sel, 4'hF);
        chk("post_reset_ready", load_ready, 1'b1);
        chk("sb_drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
